id_stage_pipe: RTL and testbench

Parametrised successor of the unpipelined decode stage. It decodes one RV32I instruction per cycle, reads the register file with write-back bypass, and generates the immediate. Results are captured in an ID/EX output register behind a valid/ready handshake. Adds load-use hazard detection (bubble insertion), flush, and refresh of held operands, none of which the single-cycle decoder has. Sits between the IF stage and the EX stage.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/regfile_bypass.sv | 42 ++++
 rtl/id_stage_pipe.sv | 156 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and per-opcode
// control decode used by the ID stage.
package rv_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   typedef struct packed {
      logic     use1;
      logic     use2;
      logic     reg_write;
      logic     mem_read;
      imm_fmt_e fmt;
   } dec_t;

   function automatic dec_t decode(input logic [6:0] opc);
      dec_t d;
      d.use1      = !((opc == LUI) || (opc == AUIPC) || (opc == JAL));
      d.use2      = (opc == OP) || (opc == STORE) || (opc == BRANCH);
      d.reg_write = !((opc == STORE) || (opc == BRANCH));
      d.mem_read  = (opc == LOAD);
      case (opc)
         OP_IMM, LOAD, JALR: d.fmt = IMM_I;
         STORE:              d.fmt = IMM_S;
         BRANCH:             d.fmt = IMM_B;
         LUI, AUIPC:         d.fmt = IMM_U;
         JAL:                d.fmt = IMM_J;
         default:            d.fmt = IMM_NONE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read / one-write register file with write-first bypass; x0 and indices
// at or above NREGS read as zero and are never written.
module regfile_bypass
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int RAW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            ra1_ok, ra2_ok, wa_ok;

   assign ra1_ok = (raddr1 != 5'd0) && (int'(raddr1) < NREGS);
   assign ra2_ok = (raddr2 != 5'd0) && (int'(raddr2) < NREGS);
   assign wa_ok  = (waddr  != 5'd0) && (int'(waddr)  < NREGS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we && wa_ok) begin
         regs_q[waddr[RAW-1:0]] <= wdata;
      end
   end

   // Same-cycle write wins so the decoder sees the value being retired.
   assign rdata1 = !ra1_ok                   ? '0    :
                   (we && (waddr == raddr1)) ? wdata : regs_q[raddr1[RAW-1:0]];
   assign rdata2 = !ra2_ok                   ? '0    :
                   (we && (waddr == raddr2)) ? wdata : regs_q[raddr2[RAW-1:0]];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined RV32I decode stage: register read with bypass, immediate generation,
// load-use bubble, flush and held-operand refresh into a handshaked ID/EX register.
module id_stage_pipe
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int RAW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc4_in,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] imm,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            mem_read,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] pc4_id
);

   typedef struct packed {
      logic [XLEN-1:0] rs1d;
      logic [XLEN-1:0] rs2d;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [4:0]      rs1i;
      logic [4:0]      rs2i;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      func3;
      logic            reg_write;
      logic            mem_read;
   } idex_t;

   logic [4:0]      rs1_a, rs2_a, rd_a;
   logic [6:0]      opc;
   dec_t            dec;
   logic [XLEN-1:0] rf_rs1, rf_rs2, imm_x;
   logic [31:0]     imm32;

   logic  vld_q, vld_d;
   idex_t idex_q, idex_d;
   logic  adv, haz, load, wb_hit;

   assign opc   = instr_in[6:0];
   assign rd_a  = instr_in[11:7];
   assign rs1_a = instr_in[19:15];
   assign rs2_a = instr_in[24:20];
   assign dec   = decode(opc);

   regfile_bypass #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .RAW   (RAW)
   ) u_rf (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1_a),
      .rdata1 (rf_rs1),
      .raddr2 (rs2_a),
      .rdata2 (rf_rs2),
      .we     (wb_we),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   always_comb begin
      imm32 = '0;
      case (dec.fmt)
         IMM_I:   imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
         IMM_S:   imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
         IMM_B:   imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                           instr_in[30:25], instr_in[11:8], 1'b0};
         IMM_U:   imm32 = {instr_in[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                           instr_in[20], instr_in[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_x = XLEN'($signed(imm32));

   // Load-use: a load in ID/EX whose result a consumer needs forces one bubble.
   assign adv      = ~vld_q | ex_ready;
   assign haz      = vld_q & idex_q.mem_read & (idex_q.rd != 5'd0) &
                     ((dec.use1 & (rs1_a == idex_q.rd)) | (dec.use2 & (rs2_a == idex_q.rd)));
   assign if_ready = flush | (adv & ~haz);
   assign load     = ~flush & adv & if_valid & ~haz;
   assign wb_hit   = wb_we & (wb_rd != 5'd0) & (int'(wb_rd) < NREGS);

   always_comb begin
      vld_d  = vld_q;
      idex_d = idex_q;
      if (flush) begin
         vld_d = 1'b0;
      end else if (adv) begin
         vld_d = if_valid & ~haz;
         if (load) begin
            idex_d.rs1d      = rf_rs1;
            idex_d.rs2d      = rf_rs2;
            idex_d.imm       = imm_x;
            idex_d.pc        = pc_in;
            idex_d.pc4       = pc4_in;
            idex_d.rs1i      = rs1_a;
            idex_d.rs2i      = rs2_a;
            idex_d.rd        = rd_a;
            idex_d.opcode    = opc;
            idex_d.func3     = instr_in[14:12];
            idex_d.reg_write = dec.reg_write;
            idex_d.mem_read  = dec.mem_read;
         end
      end else begin
         // Held instruction keeps tracking retirements so EX never sees stale operands.
         if (wb_hit && (wb_rd == idex_q.rs1i)) idex_d.rs1d = wb_data;
         if (wb_hit && (wb_rd == idex_q.rs2i)) idex_d.rs2d = wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         idex_q <= '0;
      end else begin
         vld_q  <= vld_d;
         idex_q <= idex_d;
      end
   end

   assign ex_valid  = vld_q;
   assign rs1_data  = idex_q.rs1d;
   assign rs2_data  = idex_q.rs2d;
   assign imm       = idex_q.imm;
   assign opcode    = idex_q.opcode;
   assign func3     = idex_q.func3;
   assign rd        = idex_q.rd;
   assign reg_write = idex_q.reg_write;
   assign mem_read  = idex_q.mem_read;
   assign pc_id     = idex_q.pc;
   assign pc4_id    = idex_q.pc4;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the decode stage.
module tb_id_stage_pipe;

   localparam int XL = 32;
   localparam int NR = 16;

   localparam logic [6:0] T_OPIMM = 7'h13, T_LOAD = 7'h03, T_STORE = 7'h23,
                          T_OP    = 7'h33, T_BR   = 7'h63, T_JAL   = 7'h6F,
                          T_JALR  = 7'h67, T_LUI  = 7'h37, T_AUIPC = 7'h17;
   localparam logic [6:0] OPS [9] = '{T_OPIMM, T_LOAD, T_STORE, T_OP, T_BR,
                                      T_JAL, T_JALR, T_LUI, T_AUIPC};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_valid, if_ready, flush, wb_we, ex_valid, ex_ready;
   logic [31:0]   instr_in, pc_in, pc4_in, wb_data;
   logic [4:0]    wb_rd, rd;
   logic [XL-1:0] rs1_data, rs2_data, imm, pc_id, pc4_id;
   logic [6:0]    opcode;
   logic [2:0]    func3;
   logic          reg_write, mem_read;

   always #5 clk = ~clk;

   id_stage_pipe #(.XLEN(XL), .NREGS(NR)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .instr_in(instr_in), .pc_in(pc_in), .pc4_in(pc4_in), .flush(flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid),
      .ex_ready(ex_ready), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .opcode(opcode), .func3(func3), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .pc_id(pc_id), .pc4_id(pc4_id)
   );

   typedef struct {
      bit          v;
      logic [31:0] rs1d, rs2d, imm, pc, pc4;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd, r1, r2;
      bit          rw, mr;
   } mstate_t;

   mstate_t     m;
   logic [31:0] mregs [32];
   int          n_chk  = 0;
   int          n_fail = 0;
   bit          rdy_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic bit uses1(input logic [6:0] op);
      return !(op == T_LUI || op == T_AUIPC || op == T_JAL);
   endfunction

   function automatic bit uses2(input logic [6:0] op);
      return (op == T_OP || op == T_STORE || op == T_BR);
   endfunction

   function automatic bit wb_ok(input bit we, input logic [4:0] a);
      return we && a != 0 && int'(a) < NR;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit we,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0 || int'(a) >= NR) return 32'h0;
      if (we && wa == a) return wd;
      return mregs[a];
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] ins);
      logic signed [31:0] v;
      case (ins[6:0])
         T_OPIMM, T_LOAD, T_JALR: v = $signed(ins[31:20]);
         T_STORE:     v = $signed({ins[31:25], ins[11:7]});
         T_BR:        v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
         T_LUI, T_AUIPC: v = {ins[31:12], 12'h000};
         T_JAL:       v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         default:     v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rdx,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [11:0] im);
      return {im, rs1, f3, rdx, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rdx, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rdx, T_OP};
   endfunction

   function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [11:0] im);
      return {im[11:5], rs2, rs1, 3'b010, im[4:0], T_STORE};
   endfunction

   function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [12:0] im);
      return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], T_BR};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, c;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      b = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      return {7'($urandom), b, a, 3'($urandom), c, OPS[$urandom_range(0, 8)]};
   endfunction

   task automatic model_reset();
      m = '{default: '0};
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
   endtask

   task automatic compare_outputs();
      check("ex_valid", 32'(ex_valid), 32'(m.v));
      if (m.v) begin
         check("rs1_data", rs1_data, m.rs1d);
         check("rs2_data", rs2_data, m.rs2d);
         check("imm", imm, m.imm);
         check("pc_id", pc_id, m.pc);
         check("pc4_id", pc4_id, m.pc4);
         check("opcode", 32'(opcode), 32'(m.op));
         check("func3", 32'(func3), 32'(m.f3));
         check("rd", 32'(rd), 32'(m.rd));
         check("reg_write", 32'(reg_write), 32'(m.rw));
         check("mem_read", 32'(mem_read), 32'(m.mr));
      end
   endtask

   // One clock of traffic; entered and left 1 time unit after a rising edge.
   task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit er);
      bit         adv, haz, rdy;
      mstate_t    nx;
      logic [4:0] r1, r2;
      logic [6:0] op;
      if_valid = iv; instr_in = ins; pc_in = pc; pc4_in = pc + 32'd4;
      flush = fl; wb_we = we; wb_rd = wa; wb_data = wd; ex_ready = er;
      op  = ins[6:0];
      r1  = ins[19:15];
      r2  = ins[24:20];
      adv = !m.v || er;
      haz = m.v && m.mr && m.rd != 0 &&
            ((uses1(op) && r1 == m.rd) || (uses2(op) && r2 == m.rd));
      rdy = fl || (adv && !haz);
      #4;
      rdy_seen = if_ready;
      check("if_ready", 32'(if_ready), 32'(rdy));
      nx = m;
      if (fl) begin
         nx.v = 0;
      end else if (adv) begin
         nx.v = iv && !haz;
         if (nx.v) begin
            nx.rs1d = m_read(r1, we, wa, wd);
            nx.rs2d = m_read(r2, we, wa, wd);
            nx.imm  = m_imm(ins);
            nx.pc   = pc;
            nx.pc4  = pc + 32'd4;
            nx.op   = op;
            nx.f3   = ins[14:12];
            nx.rd   = ins[11:7];
            nx.r1   = r1;
            nx.r2   = r2;
            nx.rw   = !(op == T_STORE || op == T_BR);
            nx.mr   = (op == T_LOAD);
         end
      end else begin
         if (wb_ok(we, wa) && wa == m.r1) nx.rs1d = wd;
         if (wb_ok(we, wa) && wa == m.r2) nx.rs2d = wd;
      end
      if (wb_ok(we, wa)) mregs[wa] = wd;
      m = nx;
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic idle(input bit er);
      step(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, er);
   endtask

   initial begin
      if_valid = 0; instr_in = 0; pc_in = 0; pc4_in = 0; flush = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ex_valid", 32'(ex_valid), 32'h0);
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_imm", imm, 32'h0);
      check("rst_pc", pc_id, 32'h0);
      check("rst_ctl", {21'b0, opcode, rd[3:0]}, 32'h0);
      rst = 0;

      // Bypass of a same-cycle write-back into the decoded operand.
      step(1, enc_i(T_OPIMM, 5'd6, 5'd5, 3'd0, 12'd1), 32'h100, 0, 1, 5'd5, 32'h1234, 1);
      check("t1_rs1", rs1_data, 32'h1234);
      check("t1_imm", imm, 32'h1);
      check("t1_vld", 32'(ex_valid), 32'h1);

      // Load-use bubble.
      step(1, enc_i(T_LOAD, 5'd7, 5'd1, 3'd2, 12'd0), 32'h104, 0, 0, 5'd0, 32'h0, 1);
      step(1, enc_r(5'd8, 5'd7, 5'd2), 32'h108, 0, 0, 5'd0, 32'h0, 1);
      check("t2_stall_rdy", 32'(rdy_seen), 32'h0);
      check("t2_bubble", 32'(ex_valid), 32'h0);
      step(1, enc_r(5'd8, 5'd7, 5'd2), 32'h108, 0, 0, 5'd0, 32'h0, 1);
      check("t2_issue_vld", 32'(ex_valid), 32'h1);
      check("t2_issue_rd", 32'(rd), 32'd8);

      // Held operand refresh.
      step(1, enc_r(5'd3, 5'd4, 5'd5), 32'h10C, 0, 0, 5'd0, 32'h0, 1);
      step(0, 32'h0, 32'h0, 0, 1, 5'd4, 32'hDEAD, 0);
      check("t3_refresh", rs1_data, 32'hDEAD);
      check("t3_rs2_keep", rs2_data, 32'h1234);
      check("t3_rd_keep", 32'(rd), 32'd3);
      check("t3_pc_keep", pc_id, 32'h10C);
      idle(1);

      // Flush drops the presented branch and clears ID/EX.
      step(1, enc_i(T_OPIMM, 5'd9, 5'd1, 3'd0, 12'h7FF), 32'h110, 0, 0, 5'd0, 32'h0, 1);
      step(1, enc_b(5'd1, 5'd2, 13'h8), 32'h114, 1, 0, 5'd0, 32'h0, 0);
      check("t4_flush_rdy", 32'(rdy_seen), 32'h1);
      check("t4_flush_vld", 32'(ex_valid), 32'h0);
      idle(1);
      check("t4_no_issue", 32'(ex_valid), 32'h0);

      // x0 writes ignored; indices >= NREGS read zero; control decode.
      step(0, 32'h0, 32'h0, 0, 1, 5'd0, 32'hFFFF, 1);
      step(1, enc_i(T_OPIMM, 5'd9, 5'd0, 3'd0, 12'd0), 32'h118, 0, 0, 5'd0, 32'h0, 1);
      check("t5_x0", rs1_data, 32'h0);
      step(1, enc_i(T_OPIMM, 5'd9, 5'd20, 3'd0, 12'd0), 32'h11C, 0, 1, 5'd20, 32'h55, 1);
      check("t5_oob", rs1_data, 32'h0);
      step(1, enc_s(5'd1, 5'd2, 12'h804), 32'h120, 0, 0, 5'd0, 32'h0, 1);
      check("t5_sw_rw", 32'(reg_write), 32'h0);
      check("t5_sw_imm", imm, 32'hFFFFF804);
      step(1, enc_b(5'd1, 5'd2, 13'h1FF0), 32'h124, 0, 0, 5'd0, 32'h0, 1);
      check("t5_beq_rw", 32'(reg_write), 32'h0);
      check("t5_beq_mr", 32'(mem_read), 32'h0);
      check("t5_beq_imm", imm, 32'hFFFFFFF0);
      step(1, enc_i(T_LOAD, 5'd10, 5'd1, 3'd2, 12'd4), 32'h128, 0, 0, 5'd0, 32'h0, 1);
      check("t5_lw_mr", 32'(mem_read), 32'h1);

      // Asynchronous reset while holding.
      step(1, enc_r(5'd3, 5'd4, 5'd5), 32'h12C, 0, 0, 5'd0, 32'h0, 1);
      idle(0);
      #2 rst = 1;
      #1;
      check("t6_vld", 32'(ex_valid), 32'h0);
      check("t6_rs1", rs1_data, 32'h0);
      check("t6_rs2", rs2_data, 32'h0);
      check("t6_pc", pc_id, 32'h0);
      check("t6_ctl", {20'b0, opcode, rd}, 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst = 0;

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) != 0, rand_instr(), $urandom,
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5)),
              $urandom, $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
